// File: rtl/bus3_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bus3_rr_arbiter_pkg
//  Purpose : Shared encodings and helper functions for the 3-way round-robin
//            bus arbiter (mux select codes, FSM states, hold counter width,
//            rotating-priority pick).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package bus3_rr_arbiter_pkg;

    // Select codes understood by bit32_3to1mux
    localparam logic [1:0] SEL_IN1 = 2'b00;
    localparam logic [1:0] SEL_IN2 = 2'b01;
    localparam logic [1:0] SEL_IN3 = 2'b10;

    // Hold counter width; large enough for MAX_HOLD up to 15
    localparam int HOLD_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Map a one-hot (or zero) grant to the mux select code.
    function automatic logic [1:0] gnt_to_sel(input logic [2:0] gnt);
        logic [1:0] sel;
        if (gnt[2])      sel = SEL_IN3;
        else if (gnt[1]) sel = SEL_IN2;
        else             sel = SEL_IN1;
        return sel;
    endfunction

    // Pick the first requester scanning ptr, ptr+1, ptr+2 (mod 3).
    // The loop runs from the farthest offset down so the nearest one wins.
    // A pointer value of 3 cannot occur but is treated as 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] base;
        logic [2:0] sum;
        logic [1:0] idx;
        logic [2:0] pick;
        base = (ptr == 2'd3) ? 2'd0 : ptr;
        pick = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            sum = {1'b0, base} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (req[idx]) pick = 3'b001 << idx;
        end
        return pick;
    endfunction

    // Pointer value after the current owner releases: the requester after it.
    function automatic logic [1:0] ptr_after(input logic [2:0] gnt);
        logic [1:0] ptr;
        if (gnt[0])      ptr = 2'd1;
        else if (gnt[1]) ptr = 2'd2;
        else             ptr = 2'd0;
        return ptr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit32_3to1mux.sv
`default_nettype none
// ============================================================================
//  Module  : bit32_3to1mux
//  Purpose : 32-bit 3-to-1 multiplexer. sel 00=in1, 01=in2, 10=in3; the
//            unused code 11 drives zero.
//  Ports   : out_o [31:0]  selected data
//            sel_i [1:0]   select code
//            in1_i/in2_i/in3_i [31:0]  data inputs
//  Rev     : 1.0  initial release
// ============================================================================
module bit32_3to1mux
    import bus3_rr_arbiter_pkg::*;
(
    output logic [31:0] out_o,
    input  logic [1:0]  sel_i,
    input  logic [31:0] in1_i,
    input  logic [31:0] in2_i,
    input  logic [31:0] in3_i
);

    always_comb begin
        out_o = '0;
        case (sel_i)
            SEL_IN1: out_o = in1_i;
            SEL_IN2: out_o = in2_i;
            SEL_IN3: out_o = in3_i;
            default: out_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus3_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : bus3_rr_arbiter
//  Purpose : Round-robin arbiter sharing one WIDTH-bit bus between three
//            requesters. Grants are sticky up to MAX_HOLD accepted beats, then
//            rotate if someone else is waiting. One idle cycle (dout=0) always
//            separates two grants.
//  Ports   : clk              rising-edge clock
//            reset            synchronous active-high reset
//            req[2:0]         per-requester pending beat (level)
//            din0..din2       requester data, stable while its req is high
//            dout_ready       sink accepts dout this cycle
//            gnt[2:0]         registered one-hot grant, 000 when idle
//            sel[1:0]         registered mux select derived from gnt
//            dout             muxed data, zero when no grant
//            dout_valid       owner still requesting
//            beat_ack[2:0]    per-requester beat accepted this cycle
//  Rev     : 1.0  initial release
// ============================================================================
module bus3_rr_arbiter
    import bus3_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,  // must stay 32 while bit32_3to1mux is the datapath
    parameter int MAX_HOLD = 4    // 1..15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             dout_ready,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [2:0]       beat_ack
);

    arb_state_e        state_q;
    logic [2:0]        gnt_q;
    logic [1:0]        sel_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [1:0]        rr_ptr_q;

    logic [2:0]        gnt_d;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [1:0]        rr_ptr_d;
    logic              owner_req;
    logic              accept;
    logic              last_beat;
    logic              others_waiting;
    logic              release_now;
    logic [31:0]       dout_raw;

    assign owner_req      = |(gnt_q & req);
    assign accept         = owner_req & dout_ready;
    assign last_beat      = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    assign others_waiting = |(req & ~gnt_q);

    // An owner dropping req always wins over the hold limit; the hold-limit
    // release needs an accepted beat and so can only fire while req[g] is high.
    assign release_now = (state_q == ST_GRANT) &
                         (~owner_req | (accept & last_beat & others_waiting));

    assign gnt_d      = rr_pick(req, rr_ptr_q);
    assign rr_ptr_d   = ptr_after(gnt_q);
    // Wraps to zero at the limit; that covers the keep-grant case when nobody
    // else is waiting.
    assign hold_cnt_d = last_beat ? '0 : hold_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            sel_q      <= SEL_IN1;
            hold_cnt_q <= '0;
            rr_ptr_q   <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req != 3'b000) begin
                        gnt_q   <= gnt_d;
                        sel_q   <= gnt_to_sel(gnt_d);
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gnt_q      <= 3'b000;
                        sel_q      <= SEL_IN1;
                        hold_cnt_q <= '0;
                        rr_ptr_q   <= rr_ptr_d;
                        state_q    <= ST_IDLE;
                    end else if (accept) begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 3'b000;
                    sel_q   <= SEL_IN1;
                end
            endcase
        end
    end

    bit32_3to1mux u_dmux (
        .out_o (dout_raw),
        .sel_i (sel_q),
        .in1_i (din0),
        .in2_i (din1),
        .in3_i (din2)
    );

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = (gnt_q != 3'b000) ? dout_raw : '0;
    assign dout_valid = owner_req;
    assign beat_ack   = gnt_q & req & {3{dout_ready}};

endmodule
`default_nettype wire
